// File: rtl/ahb_dec10_pkg.sv
// Shared AHB encodings used by the decoder and its default slave.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_BUSY   = 2'd1;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    DS_OKAY = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } def_state_t;

endpackage

// File: rtl/ahb_dec10_if.sv
// Address/data-phase signals exchanged between the bus fabric and the decoder.
interface ahb_dec10_if #(
  parameter int AW = 32
);
  logic [AW-1:0] haddr;
  logic [1:0]    htrans;
  logic          hready;
  logic [9:0]    hsel;
  logic [9:0]    dsel;
  logic          dsel_def;
  logic          hreadyout_def;
  logic          hresp_def;

  modport master (
    output haddr, htrans, hready,
    input  hsel, dsel, dsel_def, hreadyout_def, hresp_def
  );

  modport slave (
    input  haddr, htrans, hready,
    output hsel, dsel, dsel_def, hreadyout_def, hresp_def
  );
endinterface

// File: rtl/ahb_dec10_def_slave.sv
// Default slave: answers unmapped active transfers with a two-cycle ERROR.
module ahb_def_slave
  import ahb_pkg::*;
(
  input  logic clk,
  input  logic srst,
  input  logic hready,
  input  logic active,
  input  logic unmapped,
  output logic hreadyout,
  output logic hresp
);

  def_state_t state_reg;
  logic       hreadyout_reg;
  logic       hresp_reg;
  logic       err_start;

  assign err_start = hready && unmapped && active;

  always_ff @(posedge clk) begin
    if (srst) begin
      state_reg     <= DS_OKAY;
      hreadyout_reg <= 1'b1;
      hresp_reg     <= HRESP_OKAY;
    end else begin
      case (state_reg)
        // ERR1 owns the bus wait state, so hready is irrelevant there.
        DS_ERR1: begin
          state_reg     <= DS_ERR2;
          hreadyout_reg <= 1'b1;
          hresp_reg     <= HRESP_ERROR;
        end
        DS_OKAY, DS_ERR2: begin
          if (err_start) begin
            state_reg     <= DS_ERR1;
            hreadyout_reg <= 1'b0;
            hresp_reg     <= HRESP_ERROR;
          end else begin
            state_reg     <= DS_OKAY;
            hreadyout_reg <= 1'b1;
            hresp_reg     <= HRESP_OKAY;
          end
        end
        default: begin
          state_reg     <= DS_OKAY;
          hreadyout_reg <= 1'b1;
          hresp_reg     <= HRESP_OKAY;
        end
      endcase
    end
  end

  assign hreadyout = hreadyout_reg;
  assign hresp     = hresp_reg;

endmodule

// File: rtl/ahb_dec10.sv
// Ten-region AHB address decoder with data-phase select tracking and a default slave.
module ahb_dec10
  import ahb_pkg::*;
#(
  parameter int                AW       = 32,
  parameter int                DECW     = 4,
  parameter logic [10*DECW-1:0] SLV_BASE = 40'h9876543210,
  parameter logic [9:0]        SLV_EN   = 10'h3FF
) (
  input logic        hclk,
  input logic        hreset,
  ahb_dec10_if.slave bus
);

  localparam int NSLV = 10;

  logic [DECW-1:0] tag;
  logic [NSLV-1:0] match;
  logic [NSLV-1:0] hsel_w;
  logic [NSLV-1:0] dsel_reg;
  logic            dsel_def_reg;
  logic            unmapped;
  logic            active;
  logic            unused_addr_bits;

  assign tag              = bus.haddr[AW-1 -: DECW];
  assign unused_addr_bits = ^bus.haddr;

  generate
    for (genvar gi = 0; gi < NSLV; gi++) begin : g_match
      assign match[gi] = SLV_EN[gi] && (tag == SLV_BASE[gi*DECW +: DECW]);
    end
  endgenerate

  // Isolate the lowest set bit so overlapping tags resolve to the lowest index.
  assign hsel_w   = match & (~match + {{(NSLV-1){1'b0}}, 1'b1});
  assign unmapped = ~|hsel_w;
  assign active   = (bus.htrans == HTRANS_NONSEQ) || (bus.htrans == HTRANS_SEQ);

  always_ff @(posedge hclk) begin
    if (hreset) begin
      dsel_reg     <= '0;
      dsel_def_reg <= 1'b1;
    end else if (bus.hready) begin
      dsel_reg     <= hsel_w;
      dsel_def_reg <= unmapped;
    end
  end

  ahb_def_slave u_def_slave (
    .clk       (hclk),
    .srst      (hreset),
    .hready    (bus.hready),
    .active    (active),
    .unmapped  (unmapped),
    .hreadyout (bus.hreadyout_def),
    .hresp     (bus.hresp_def)
  );

  assign bus.hsel     = hsel_w;
  assign bus.dsel     = dsel_reg;
  assign bus.dsel_def = dsel_def_reg;

endmodule

// File: tb/tb_ahb_dec10.sv
// Randomised scoreboard bench for ahb_dec10 with a transaction-level reference model.
module tb_ahb_dec10;

  logic hclk = 1'b0;
  logic hreset;

  always #5 hclk = ~hclk;

  ahb_dec10_if #(.AW(32)) bus ();

  // Slave 7 deliberately overlaps slave 3's tag; slave 0 is disabled.
  ahb_dec10 #(
    .AW       (32),
    .DECW     (4),
    .SLV_BASE (40'h9836543210),
    .SLV_EN   (10'h3FE)
  ) dut (
    .hclk   (hclk),
    .hreset (hreset),
    .bus    (bus)
  );

  typedef struct {
    int         idx;
    logic [9:0] hsel;
    logic [9:0] dsel;
    logic       def;
    logic       rdy;
    logic       resp;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   txn    = 0;

  int         tag_tab[10] = '{0, 1, 2, 3, 4, 5, 6, 3, 8, 9};
  logic [9:0] en_tab      = 10'h3FE;

  // Model: data-phase owner and how many ERROR cycles are still owed.
  logic [9:0] m_dsel;
  logic       m_def;
  int         m_err_left;

  function automatic logic [9:0] ref_hsel(input logic [31:0] a);
    ref_hsel = '0;
    for (int i = 0; i < 10; i++) begin
      if (en_tab[i] && (int'(a[31:28]) == tag_tab[i])) begin
        ref_hsel = 10'(1) << i;
        return ref_hsel;
      end
    end
  endfunction

  function automatic logic model_rdy();
    return m_err_left != 2;
  endfunction

  task automatic cycle(input logic [31:0] a, input logic [1:0] t, input logic r, input logic rst);
    exp_t       e;
    logic [9:0] hs;
    @(negedge hclk);
    bus.haddr  = a;
    bus.htrans = t;
    bus.hready = r;
    hreset     = rst;
    hs         = ref_hsel(a);
    e.idx  = txn;
    e.hsel = hs;
    e.dsel = m_dsel;
    e.def  = m_def;
    e.rdy  = (m_err_left != 2);
    e.resp = (m_err_left != 0);
    q.push_back(e);
    txn++;
    @(posedge hclk);
    if (rst) begin
      m_dsel     = '0;
      m_def      = 1'b1;
      m_err_left = 0;
    end else begin
      if (r) begin
        m_dsel = hs;
        m_def  = (hs == 0);
      end
      if (m_err_left == 2)
        m_err_left = 1;
      else if (r && hs == 0 && t[1])
        m_err_left = 2;
      else
        m_err_left = 0;
    end
  endtask

  task automatic chk(input string name, input int idx, input logic [9:0] got, input logic [9:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s txn=%0d got=%h expected=%h", name, idx, got, exp);
    end
  endtask

  // Monitor: every cycle the DUT presents a response, compare it with the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge hclk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("hsel",          e.idx, bus.hsel, e.hsel);
        chk("dsel",          e.idx, bus.dsel, e.dsel);
        chk("dsel_def",      e.idx, 10'(bus.dsel_def), 10'(e.def));
        chk("hreadyout_def", e.idx, 10'(bus.hreadyout_def), 10'(e.rdy));
        chk("hresp_def",     e.idx, 10'(bus.hresp_def), 10'(e.resp));
        $display("txn %0d addr=%h trans=%0d rdy=%b hsel=%h dsel=%h def=%b ro=%b resp=%b",
                 e.idx, bus.haddr, bus.htrans, bus.hready, bus.hsel, bus.dsel,
                 bus.dsel_def, bus.hreadyout_def, bus.hresp_def);
      end
    end
  end

  initial begin
    int wait_cycles;
    logic [31:0] a;
    logic [1:0]  t;
    logic        r;
    bus.haddr  = '0;
    bus.htrans = 2'd0;
    bus.hready = 1'b1;
    hreset     = 1'b1;
    m_dsel     = '0;
    m_def      = 1'b1;
    m_err_left = 0;

    // Reset then idle bus
    cycle(32'h0, 2'd0, 1'b1, 1'b1);
    cycle(32'h0, 2'd0, 1'b1, 1'b1);
    cycle(32'h0000_0000, 2'd0, 1'b1, 1'b0);
    // Mapped NONSEQ to slave 3 (tag overlap resolves to 3)
    cycle(32'h3000_0000, 2'd2, 1'b1, 1'b0);
    cycle(32'hA000_0000, 2'd0, 1'b1, 1'b0);
    // Unmapped NONSEQ to disabled slave 0: ERR1, ERR2, OKAY
    cycle(32'h0000_0010, 2'd2, 1'b1, 1'b0);
    cycle(32'h1000_0000, 2'd0, model_rdy(), 1'b0);
    cycle(32'h1000_0000, 2'd0, model_rdy(), 1'b0);
    cycle(32'h1000_0000, 2'd0, model_rdy(), 1'b0);
    // Unmapped IDLE / BUSY stay OKAY
    cycle(32'hB000_0000, 2'd0, 1'b1, 1'b0);
    cycle(32'h7000_0000, 2'd1, 1'b1, 1'b0);
    cycle(32'h2000_0000, 2'd0, 1'b1, 1'b0);
    // dsel holds while hready is low
    cycle(32'h5000_0000, 2'd2, 1'b1, 1'b0);
    cycle(32'h8000_0000, 2'd2, 1'b0, 1'b0);
    cycle(32'hC000_0000, 2'd3, 1'b0, 1'b0);
    cycle(32'h1000_0000, 2'd2, 1'b0, 1'b0);
    cycle(32'h1000_0000, 2'd0, 1'b1, 1'b0);
    // Back-to-back unmapped NONSEQ, second issued during ERR2; hready=1 in ERR1 must be ignored
    cycle(32'hC000_0000, 2'd2, 1'b1, 1'b0);
    cycle(32'hD000_0000, 2'd2, 1'b1, 1'b0);
    cycle(32'hD000_0000, 2'd2, 1'b1, 1'b0);
    cycle(32'h0000_0000, 2'd0, model_rdy(), 1'b0);
    cycle(32'h0000_0000, 2'd0, model_rdy(), 1'b0);
    cycle(32'h0000_0000, 2'd0, 1'b1, 1'b0);
    // Reset during ERR1
    cycle(32'hE000_0000, 2'd2, 1'b1, 1'b0);
    cycle(32'hE000_0000, 2'd2, 1'b0, 1'b1);
    cycle(32'h4000_0000, 2'd0, 1'b1, 1'b0);
    cycle(32'h4000_0000, 2'd0, 1'b1, 1'b0);

    for (int n = 0; n < 400; n++) begin
      a = {4'($urandom_range(15)), 28'($urandom)};
      t = 2'($urandom_range(3));
      r = ($urandom_range(3) == 0) ? 1'($urandom) : model_rdy();
      cycle(a, t, r, ($urandom_range(60) == 0));
    end
    cycle(32'h0, 2'd0, 1'b1, 1'b0);

    wait_cycles = 0;
    while (q.size() > 0 && wait_cycles < 20) begin
      @(posedge hclk);
      wait_cycles++;
    end
    @(negedge hclk);
    #3;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d expected=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
